// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary decoder: default size, FSM
// encoding and the digit-legality helper.
package bcd_pkg;

  // Default number of BCD digits handled by one conversion.
  localparam int DIGITS_DEFAULT = 4;

  // Largest value a legal BCD nibble may hold.
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // Threshold and correction used by the reverse double-dabble step.
  localparam logic [3:0] ADJ_THRESHOLD = 4'd8;
  localparam logic [3:0] ADJ_AMOUNT    = 4'd3;

  // Converter states: waiting, shifting, and the one-cycle result slot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the nibble encodes a decimal digit 0..9.
  function automatic logic nibble_is_digit(input logic [3:0] nibble);
    return (nibble <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_nibble_adjust_down.sv
// Per-nibble correction for reverse double-dabble: any nibble holding 8 or
// more after the right shift gets 3 subtracted, independently per nibble.
module bcd_nibble_adjust_down
  import bcd_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] bcd_in,
  output logic [W-1:0] bcd_out
);

  localparam int NIBBLES = W / 4;

  for (genvar g = 0; g < NIBBLES; g++) begin : g_nibble
    logic [3:0] nib;
    logic [3:0] nib_adj;

    assign nib = bcd_in[4*g +: 4];

    // Subtract 3 (mod 16) from this nibble when it is 8 or above.
    always_comb begin
      nib_adj = nib;
      if (nib >= ADJ_THRESHOLD) begin
        nib_adj = nib - ADJ_AMOUNT;
      end
    end

    assign bcd_out[4*g +: 4] = nib_adj;
  end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary decoder using reverse double-dabble, one shift
// per clock, with a start/busy/done handshake and illegal-digit detection.
module bcd_to_bin_converter
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [4*DIGITS-1:0] bin_out
);

  localparam int W     = 4 * DIGITS;
  localparam int ITER  = 4 * DIGITS;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2*W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [W-1:0]     bin_q, bin_d;

  logic             all_valid;
  logic [2*W-1:0]   sr_shifted;
  logic [W-1:0]     upper_adj;
  logic [2*W-1:0]   sr_step;

  // Flag the incoming word as legal only if every nibble is 0..9.
  always_comb begin
    all_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!nibble_is_digit(bcd_in[4*i +: 4])) begin
        all_valid = 1'b0;
      end
    end
  end

  // One reverse double-dabble step: shift right, then correct BCD nibbles.
  always_comb begin
    sr_shifted = sr_q >> 1;
  end

  bcd_nibble_adjust_down #(
    .W (W)
  ) u_adjust (
    .bcd_in  (sr_shifted[2*W-1:W]),
    .bcd_out (upper_adj)
  );

  assign sr_step = {upper_adj, sr_shifted[W-1:0]};

  // Next-state and datapath decisions; outputs are registered from state_d.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bin_d   = bin_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (all_valid) begin
            sr_d    = {bcd_in, {W{1'b0}}};
            cnt_d   = '0;
            state_d = CONV;
          end else begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end
        end
      end

      CONV: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          bin_d   = sr_step[W-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers, cleared synchronously by rst in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Scoreboard bench for bcd_to_bin_converter (DIGITS = 4).
module tb_bcd_to_bin_converter;

  localparam int ITER = 16;

  typedef struct {
    logic [15:0] bin;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] bin_out;

  int   tests_run;
  int   tests_failed;
  int   cycle;
  exp_t exp_q[$];
  logic spacing_en;
  logic have_last;
  int   last_done;

  bcd_to_bin_converter #(
    .DIGITS (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to time accepts and done pulses.
  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Independent binary-to-BCD model used to build legal input words.
  function automatic logic [15:0] to_bcd(input int value);
    logic [15:0] r;
    int v;
    v = value;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Wait at a falling edge until the converter is idle, bounded.
  task automatic waitIdle();
    int budget;
    budget = 0;
    @(negedge clk);
    while (busy === 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (busy !== 1'b0) checkOutput("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one request in the first idle cycle and queue its expected result.
  task automatic applyStimulus(input logic [15:0] word, input logic [15:0] exp_bin,
                               input logic exp_err);
    exp_t e;
    waitIdle();
    start  = 1'b1;
    bcd_in = word;
    e.bin  = exp_bin;
    e.err  = exp_err;
    e.acc  = cycle + 1;
    e.lat  = exp_err ? 0 : ITER;
    exp_q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait until every queued result has been seen, bounded.
  task automatic waitDrain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || busy === 1'b1) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: on every done pulse, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("bin_out", 32'(bin_out), 32'(e.bin));
        checkOutput("err", 32'(err), 32'(e.err));
        checkOutput("done_latency", 32'(cycle - e.acc), 32'(e.lat));
        checkOutput("busy_in_done", 32'(busy), 32'd1);
      end
      if (spacing_en && have_last) begin
        checkOutput("done_spacing", 32'(cycle - last_done), 32'(ITER + 2));
      end
      last_done = cycle;
      have_last = spacing_en;
    end
  end

  initial begin
    exp_t e;
    tests_run    = 0;
    tests_failed = 0;
    spacing_en   = 1'b0;
    have_last    = 1'b0;
    last_done    = 0;
    rst          = 1'b1;
    start        = 1'b0;
    bcd_in       = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_bin", 32'(bin_out), 32'd0);
    rst = 1'b0;

    applyStimulus(16'h9999, 16'h270F, 1'b0);
    applyStimulus(16'h1234, 16'h04D2, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    applyStimulus(16'h12A4, 16'h0000, 1'b1);
    applyStimulus(16'h0042, 16'h002A, 1'b0);
    waitDrain();

    // Start pulses and input changes during a conversion must be ignored.
    applyStimulus(16'h0500, 16'h01F4, 1'b0);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0999;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'h7777;
    waitDrain();
    repeat (25) @(negedge clk);

    // Holding start high yields two back-to-back conversions.
    waitIdle();
    start  = 1'b1;
    bcd_in = 16'h0007;
    e.bin = 16'h0007; e.err = 1'b0; e.acc = cycle + 1; e.lat = ITER;
    exp_q.push_back(e);
    e.acc = e.acc + ITER + 2;
    exp_q.push_back(e);
    repeat (20) @(negedge clk);
    start = 1'b0;
    waitDrain();

    // Reset mid-conversion aborts without a done pulse.
    waitIdle();
    start  = 1'b1;
    bcd_in = 16'h8888;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_bin", 32'(bin_out), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    repeat (30) @(negedge clk);
    applyStimulus(16'h0010, 16'h000A, 1'b0);
    waitDrain();

    // Round trip through the bench's encoder model with back-to-back starts.
    spacing_en = 1'b1;
    for (int v = 0; v < 10000; v += 101) begin
      applyStimulus(to_bcd(v), 16'(v), 1'b0);
    end
    applyStimulus(to_bcd(9999), 16'd9999, 1'b0);
    waitDrain();
    spacing_en = 1'b0;

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
